// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up raw push-button / switch pins for synchronous control logic.
// Each channel is an independent chain of:
//   synchronizer -> debouncer -> edge-qualified single pulser (+ auto-repeat)
//
// Parameters
//   CHANNELS     number of independent input channels (>= 1)
//   SYNC_STAGES  flip-flops in each synchronizer chain (>= 2)
//   DEBOUNCE_CNT consecutive disagreeing cycles needed to accept a new level
//   EDGE_MODE    0 = pulse on press (rise), 1 = on release (fall), 2 = both
//   REPEAT_CNT   auto-repeat period while held (0 = off; unused in mode 1)
//
// Ports
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous, active-low reset
//   press_i  raw asynchronous inputs, active-high, one bit per channel
//   level_o  debounced level per channel (registered)
//   SP_o     one-cycle pulse per qualified event or repeat tick (registered)
//
// There is no combinational path from press_i to any output.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4,
  parameter int EDGE_MODE    = 0,
  parameter int REPEAT_CNT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] press_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] SP_o
);

  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);

  // The repeat counter still needs a legal width when auto-repeat is off.
  localparam int RW = (REPEAT_CNT > 0) ? $clog2(REPEAT_CNT + 1) : 1;
  localparam logic [RW-1:0] R_LAST = (REPEAT_CNT > 0) ? RW'(REPEAT_CNT - 1) : '0;

  localparam bit PULSE_RISE = (EDGE_MODE != 1);
  localparam bit PULSE_FALL = (EDGE_MODE != 0);
  localparam bit REP_EN     = (REPEAT_CNT > 0) && (EDGE_MODE != 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q;
    logic [RW-1:0]          rcnt_q;
    logic                   level_q;
    logic                   sp_q;
    logic                   s;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    // The synchronized input has disagreed with the current level for
    // DEBOUNCE_CNT consecutive cycles: the new level is taken this edge.
    assign accept = (s != level_q) && (dcnt_q == D_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= '0;
        dcnt_q  <= '0;
        rcnt_q  <= '0;
        level_q <= 1'b0;
        sp_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], press_i[g]};
        sp_q   <= 1'b0;

        // Debounce: any agreeing cycle restarts the count.
        if (s == level_q) begin
          dcnt_q <= '0;
        end else if (accept) begin
          dcnt_q  <= '0;
          level_q <= s;
          sp_q    <= s ? PULSE_RISE : PULSE_FALL;
        end else begin
          dcnt_q <= dcnt_q + DW'(1);
        end

        // Auto-repeat. The counter sits at 0 while released and on the edge
        // the level changes, so a repeat tick can never coincide with an
        // edge pulse; a release also ends the train immediately.
        if (!REP_EN || !level_q || accept) begin
          rcnt_q <= '0;
        end else if (rcnt_q == R_LAST) begin
          rcnt_q <= '0;
          sp_q   <= 1'b1;
        end else begin
          rcnt_q <= rcnt_q + RW'(1);
        end
      end
    end

    assign level_o[g] = level_q;
    assign SP_o[g]    = sp_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Four instances share one clock, reset and 2-bit input bus:
//   u_m0  EDGE_MODE 0, no repeat
//   u_m1  EDGE_MODE 1, REPEAT_CNT 8 (repeat must be ignored)
//   u_m2  EDGE_MODE 2, no repeat
//   u_rp  EDGE_MODE 0, REPEAT_CNT 8
// Every cycle the driver applies an input, advances a behavioural model
// ("level follows the synchronized input once it has been stable for
// DEBOUNCE_CNT samples") and pushes the expected outputs; the monitor pops
// and compares one entry per clock edge. Table rows and hand-written
// sequences additionally check pulse counts taken from the test plan.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int REP  = 8;
  localparam int HW   = SYNC + DB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] press_i = 2'b00;

  always #5 clk = ~clk;

  logic [1:0] lv_m0, sp_m0, lv_m1, sp_m1, lv_m2, sp_m2, lv_rp, sp_rp;

  button_conditioner #(.CHANNELS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CNT(DB),
                       .EDGE_MODE(0), .REPEAT_CNT(0)) u_m0 (
    .clk(clk), .rst(rst), .press_i(press_i), .level_o(lv_m0), .SP_o(sp_m0));

  button_conditioner #(.CHANNELS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CNT(DB),
                       .EDGE_MODE(1), .REPEAT_CNT(REP)) u_m1 (
    .clk(clk), .rst(rst), .press_i(press_i), .level_o(lv_m1), .SP_o(sp_m1));

  button_conditioner #(.CHANNELS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CNT(DB),
                       .EDGE_MODE(2), .REPEAT_CNT(0)) u_m2 (
    .clk(clk), .rst(rst), .press_i(press_i), .level_o(lv_m2), .SP_o(sp_m2));

  button_conditioner #(.CHANNELS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CNT(DB),
                       .EDGE_MODE(0), .REPEAT_CNT(REP)) u_rp (
    .clk(clk), .rst(rst), .press_i(press_i), .level_o(lv_rp), .SP_o(sp_rp));

  // ---------------- scoreboard state ----------------
  // Entry: {level[1:0], pulses[7:0]}, pulse bit = 2*instance + channel,
  // instance order m0, m1, m2, rp.
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cnt[8];

  // model state
  logic [HW-1:0] hist [2];
  logic [1:0]    mlvl;
  int            age  [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  endtask

  // ---------------- driver + model ----------------
  // Drives one cycle of input at the falling edge and pushes the outputs
  // expected right after the following rising edge.
  task automatic step(input logic r, input logic [1:0] p);
    logic [7:0] e_sp;
    e_sp = '0;
    @(negedge clk);
    rst     = r;
    press_i = p;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        hist[c] = '0;
        age[c]  = 0;
      end
      mlvl = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        logic prev, nxt, rise, fall, rep;
        hist[c] = {hist[c][HW-2:0], p[c]};
        prev = mlvl[c];
        // Window = the DB samples seen by the debouncer, SYNC edges late.
        if (&hist[c][HW-1:SYNC])       nxt = 1'b1;
        else if (~|hist[c][HW-1:SYNC]) nxt = 1'b0;
        else                           nxt = prev;
        rise = nxt & ~prev;
        fall = ~nxt & prev;
        if (rise)     age[c] = 0;
        else if (nxt) age[c] = age[c] + 1;
        rep = prev & nxt & ((age[c] % REP) == 0);
        e_sp[c]     = rise;
        e_sp[2 + c] = fall;
        e_sp[4 + c] = rise | fall;
        e_sp[6 + c] = rise | rep;
        mlvl[c]     = nxt;
      end
    end
    exp_q.push_back({mlvl, e_sp});
  endtask

  // ---------------- monitor ----------------
  logic [9:0] mon_e;
  logic [7:0] mon_sp;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_sp = {sp_rp, sp_m2, sp_m1, sp_m0};
      chk("level", int'({lv_rp, lv_m2, lv_m1, lv_m0}), int'({4{mon_e[9:8]}}));
      chk("pulse", int'(mon_sp), int'(mon_e[7:0]));
      for (int i = 0; i < 8; i++) if (mon_sp[i]) cnt[i]++;
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic       r;
    logic [1:0] p;
    int         cyc;
    logic [1:0] lvl;   // expected debounced level at end of row
    int         m0_0;  // pulses expected on u_m0 ch0 / ch1 during the row
    int         m0_1;
    int         m2_0;  // pulses expected on u_m2 ch0 / ch1 during the row
    int         m2_1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    clear_cnt();
    for (int c = 0; c < 2; c++) begin
      hist[c] = '0;
      age[c]  = 0;
    end
    mlvl = '0;

    //            r     press   cyc lvl    m0_0 m0_1 m2_0 m2_1
    tbl[0]  = '{1'b0, 2'b11,  4, 2'b00, 0, 0, 0, 0};  // held in reset
    tbl[1]  = '{1'b1, 2'b11, 10, 2'b11, 1, 1, 1, 1};  // already pressed
    tbl[2]  = '{1'b1, 2'b00, 10, 2'b00, 0, 0, 1, 1};
    tbl[3]  = '{1'b1, 2'b01, 10, 2'b01, 1, 0, 1, 0};  // clean press ch0
    tbl[4]  = '{1'b1, 2'b00, 10, 2'b00, 0, 0, 1, 0};
    tbl[5]  = '{1'b1, 2'b01,  3, 2'b00, 0, 0, 0, 0};  // bounce
    tbl[6]  = '{1'b1, 2'b00,  1, 2'b00, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 2'b01,  2, 2'b00, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 2'b00,  1, 2'b00, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 2'b01, 12, 2'b01, 1, 0, 1, 0};  // final stable rise
    tbl[10] = '{1'b1, 2'b00, 10, 2'b00, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 2'b10,  8, 2'b10, 0, 1, 0, 1};  // 8-cycle press ch1
    tbl[12] = '{1'b1, 2'b00, 10, 2'b00, 0, 0, 0, 1};

    // Row checks see every edge up to the one before the row's last drive.
    for (int i = 0; i < 13; i++) begin
      clear_cnt();
      for (int k = 0; k < tbl[i].cyc; k++) step(tbl[i].r, tbl[i].p);
      chk($sformatf("row%0d_level_m0", i), int'(lv_m0), int'(tbl[i].lvl));
      chk($sformatf("row%0d_cnt_m0_ch0", i), cnt[0], tbl[i].m0_0);
      chk($sformatf("row%0d_cnt_m0_ch1", i), cnt[1], tbl[i].m0_1);
      chk($sformatf("row%0d_cnt_m2_ch0", i), cnt[4], tbl[i].m2_0);
      chk($sformatf("row%0d_cnt_m2_ch1", i), cnt[5], tbl[i].m2_1);
    end

    // ---- auto-repeat: hold ch0 for 40 cycles ----
    // Press pulse at drive index 5, repeats at 13, 21, 29, 37; the next
    // slot (45) is the release edge, which ends the train.
    clear_cnt();
    repeat (40) step(1'b1, 2'b01);
    chk("rep_cnt_held", cnt[6], 5);
    chk("rep_level_held", int'(lv_rp), 1);
    repeat (10) step(1'b1, 2'b00);
    chk("rep_cnt_total", cnt[6], 5);
    chk("rep_cnt_ch1", cnt[7], 0);
    chk("mode1_release_only", cnt[2], 1);
    chk("mode0_single_press", cnt[0], 1);

    // ---- reset in the middle of a debounce (dcnt == 2) ----
    clear_cnt();
    repeat (4) step(1'b1, 2'b01);
    repeat (3) step(1'b0, 2'b01);
    repeat (6) step(1'b1, 2'b01);
    chk("midrst_no_early_pulse", cnt[0], 0);
    chk("midrst_no_early_level", int'(lv_m0), 0);
    step(1'b1, 2'b01);
    chk("midrst_pulse_at_6", cnt[0], 1);
    chk("midrst_level", int'(lv_m0), 1);
    repeat (10) step(1'b1, 2'b00);

    // ---- random held levels, checked cycle by cycle against the model ----
    begin
      int left;
      left = 120;
      while (left > 0) begin
        logic [1:0] v;
        int n;
        v = 2'($urandom_range(0, 3));
        n = $urandom_range(1, 9);
        repeat (n) step(1'b1, v);
        left = left - n;
      end
    end
    repeat (12) step(1'b1, 2'b00);

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
